// File: rtl/custom_axi_ip_regs_pkg.sv
// custom_axi_ip_pkg: shared types, register offsets and AXI response codes for the IP register file
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;

    localparam logic [4:0] DATA_IN_OFFS = 5'h00;
    localparam logic [4:0] CTRL_OFFS    = 5'h04;
    localparam logic [4:0] RESULT_OFFS  = 5'h08;
    localparam logic [4:0] STATUS_OFFS  = 5'h0C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word index of a byte offset, matching the addr[4:2] decode
    function automatic logic [2:0] reg_idx(input logic [4:0] offs);
        return offs[4:2];
    endfunction

endpackage

// File: rtl/custom_axi_ip_regs_if.sv
// custom_axi_ip_regs_if: AXI4-Lite bus bundle with master and slave views
interface custom_axi_ip_regs_if #(
    parameter int ADDR_WIDTH = 5
) ();

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/custom_axi_ip_regs.sv
// custom_axi_ip_regs: AXI4-Lite register file feeding operand/start to the IP core and exposing its result/state
module custom_axi_ip_regs
    import custom_axi_ip_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    custom_axi_ip_regs_if.slave        s_axi,
    output logic [31:0]                ipreg_data,
    output logic                       enable_out,
    input  logic [31:0]                result_in,
    input  status_e                    status_in
);

    if (DATA_WIDTH != 32 || ADDR_WIDTH < 5) begin : g_bad_params
        $error("custom_axi_ip_regs: DATA_WIDTH must be 32 and ADDR_WIDTH at least 5");
    end

    logic [31:0] data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        en_q, en_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    logic [2:0]  widx, ridx;
    logic        wr_acc, rd_acc;
    logic        start_hit, start_ok, start_bad;
    logic [1:0]  clr;
    logic [31:0] rd_mux;
    logic        addr_lsb_unused;

    assign widx            = s_axi.awaddr[4:2];
    assign ridx            = s_axi.araddr[4:2];
    assign addr_lsb_unused = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // Address and data are only taken together, and only once the previous response is gone
    assign wr_acc = s_axi.awvalid & s_axi.wvalid & ~bvalid_q;
    assign rd_acc = s_axi.arvalid & ~rvalid_q;

    assign s_axi.awready = wr_acc;
    assign s_axi.wready  = wr_acc;
    assign s_axi.arready = ~rvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    assign ipreg_data = data_q;
    assign enable_out = en_q;

    assign start_hit = wr_acc & (widx == reg_idx(CTRL_OFFS)) & s_axi.wdata[0] & s_axi.wstrb[0];
    assign start_ok  = start_hit & (status_in == IDLE);
    assign start_bad = start_hit & (status_in != IDLE);
    assign clr       = (wr_acc & (widx == reg_idx(STATUS_OFFS)) & s_axi.wstrb[0]) ? s_axi.wdata[3:2] : 2'b00;

    // Read mux sees register state before any same-cycle write lands
    assign rd_mux = (ridx == reg_idx(DATA_IN_OFFS)) ? data_q :
                    (ridx == reg_idx(RESULT_OFFS))  ? result_in :
                    (ridx == reg_idx(STATUS_OFFS))  ? {28'd0, err_q, done_q, status_in} :
                    32'd0;

    // Next-state for registers and both channels; sticky set terms are ORed after the clear so set wins
    always_comb begin
        data_d = data_q;
        for (int b = 0; b < 4; b++)
            if (wr_acc && widx == reg_idx(DATA_IN_OFFS) && s_axi.wstrb[b])
                data_d[8*b +: 8] = s_axi.wdata[8*b +: 8];
        done_d   = (status_in == DONE) | (done_q & ~clr[0]);
        err_d    = start_bad | (err_q & ~clr[1]);
        en_d     = start_ok;
        bvalid_d = wr_acc | (bvalid_q & ~s_axi.bready);
        bresp_d  = wr_acc ? (widx[2] ? RESP_SLVERR : RESP_OKAY) : bresp_q;
        rvalid_d = rd_acc | (rvalid_q & ~s_axi.rready);
        rresp_d  = rd_acc ? (ridx[2] ? RESP_SLVERR : RESP_OKAY) : rresp_q;
        rdata_d  = rd_acc ? rd_mux : rdata_q;
    end

    // State registers; reset drops valids and any pending start pulse at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
            en_q     <= en_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// tb_custom_axi_ip_regs: directed and randomized checks of the register file against a behavioural model
module tb_custom_axi_ip_regs;
    import custom_axi_ip_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ipreg_data;
    logic        enable_out;
    logic [31:0] result_in = '0;
    status_e     status_in = IDLE;

    custom_axi_ip_regs_if #(.ADDR_WIDTH(5)) axi ();

    custom_axi_ip_regs #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .s_axi      (axi),
        .ipreg_data (ipreg_data),
        .enable_out (enable_out),
        .result_in  (result_in),
        .status_in  (status_in)
    );

    always #5 clk = ~clk;

    // Behavioural model: software-visible register contents
    logic [31:0] m_data;
    bit          m_done, m_err;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock; the model sees the same status the DUT samples at the edge
    task automatic cyc();
        @(posedge clk);
        if (rst_n && status_in == DONE) m_done = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_bus();
        axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
        axi.bready = 0; axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;
    endtask

    task automatic do_reset();
        idle_bus();
        rst_n = 0;
        m_data = '0; m_done = 0; m_err = 0;
        repeat (2) @(negedge clk);
        check("rst_bvalid", {31'd0, axi.bvalid}, 0);
        check("rst_rvalid", {31'd0, axi.rvalid}, 0);
        check("rst_rdata", axi.rdata, 0);
        check("rst_resp", {28'd0, axi.bresp, axi.rresp}, 0);
        check("rst_ipreg", ipreg_data, 0);
        check("rst_enable", {31'd0, enable_out}, 0);
        rst_n = 1;
        cyc();
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int          idx;
        logic [1:0]  exp_resp;
        bit          exp_pulse;
        idx = int'(addr[4:2]);
        exp_resp = (idx > 3) ? 2'b10 : 2'b00;
        exp_pulse = (idx == 1) && data[0] && strb[0] && status_in == IDLE;
        axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
        axi.awvalid = 1; axi.wvalid = 1; axi.bready = 1;
        #1;
        check("wr_ready", {30'd0, axi.awready, axi.wready}, 32'd3);
        if (idx == 0)
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_data[8*b +: 8] = data[8*b +: 8];
        if (idx == 1 && data[0] && strb[0] && status_in != IDLE) m_err = 1;
        if (idx == 3 && strb[0]) begin
            if (data[2]) m_done = 0;
            if (data[3]) m_err = 0;
        end
        cyc();
        axi.awvalid = 0; axi.wvalid = 0;
        check("wr_bvalid", {31'd0, axi.bvalid}, 1);
        check("wr_bresp", {30'd0, axi.bresp}, {30'd0, exp_resp});
        check("wr_pulse", {31'd0, enable_out}, {31'd0, exp_pulse});
        check("wr_ipreg", ipreg_data, m_data);
        cyc();
        check("wr_bdone", {31'd0, axi.bvalid}, 0);
        check("wr_pulse_end", {31'd0, enable_out}, 0);
        axi.bready = 0;
    endtask

    task automatic rd(input logic [4:0] addr, input int hold);
        int          idx;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        idx = int'(addr[4:2]);
        exp_data = (idx == 0) ? m_data :
                   (idx == 2) ? result_in :
                   (idx == 3) ? {28'd0, m_err, m_done, 2'(status_in)} : 32'd0;
        exp_resp = (idx > 3) ? 2'b10 : 2'b00;
        axi.araddr = addr; axi.arvalid = 1; axi.rready = 0;
        #1;
        check("rd_arready", {31'd0, axi.arready}, 1);
        cyc();
        axi.arvalid = 0;
        for (int i = 0; i <= hold; i++) begin
            check("rd_rvalid", {31'd0, axi.rvalid}, 1);
            check("rd_rdata", axi.rdata, exp_data);
            check("rd_rresp", {30'd0, axi.rresp}, {30'd0, exp_resp});
            if (i < hold) cyc();
        end
        axi.rready = 1;
        cyc();
        check("rd_rdone", {31'd0, axi.rvalid}, 0);
        axi.rready = 0;
    endtask

    initial begin
        do_reset();
        status_in = IDLE;

        wr(5'h00, 32'h0000_00A5, 4'hF);
        check("data_a5", ipreg_data, 32'h0000_00A5);
        wr(5'h00, 32'hFFFF_FFFF, 4'h2);
        check("data_strb", ipreg_data, 32'h0000_FFA5);

        wr(5'h04, 32'h1, 4'hF);
        status_in = BUSY;
        wr(5'h04, 32'h1, 4'hF);
        rd(5'h0C, 0);
        check("start_err_set", {31'd0, m_err}, 1);

        status_in = DONE; result_in = 32'h0000_00A6;
        cyc();
        status_in = IDLE;
        rd(5'h08, 1);
        rd(5'h0C, 0);
        wr(5'h0C, 32'h4, 4'hF);
        rd(5'h0C, 0);
        wr(5'h0C, 32'h8, 4'hF);
        rd(5'h0C, 2);

        rd(5'h14, 0);
        wr(5'h18, 32'hDEAD_BEEF, 4'hF);
        check("unmapped_wr", ipreg_data, 32'h0000_FFA5);

        // Response back-pressure: a second request must wait behind the unacknowledged one
        axi.awaddr = 5'h00; axi.wdata = 32'h1122_3344; axi.wstrb = 4'hF;
        axi.awvalid = 1; axi.wvalid = 1; axi.bready = 0;
        m_data = 32'h1122_3344;
        cyc();
        axi.wdata = 32'h5566_7788;
        repeat (5) begin
            #1;
            check("bp_bvalid", {31'd0, axi.bvalid}, 1);
            check("bp_ready", {30'd0, axi.awready, axi.wready}, 0);
            cyc();
        end
        check("bp_data", ipreg_data, 32'h1122_3344);
        axi.awvalid = 0; axi.wvalid = 0; axi.bready = 1;
        cyc();
        check("bp_release", {31'd0, axi.bvalid}, 0);
        axi.bready = 0;

        // Random traffic against the model
        for (int n = 0; n < 120; n++) begin
            int          r;
            logic [4:0]  a;
            logic [31:0] d;
            r = int'($urandom_range(0, 9));
            status_in = (r < 6) ? IDLE : (r < 8) ? BUSY : (r < 9) ? DONE : ERROR;
            result_in = $urandom;
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) d[0] = 1'b1;
            if ($urandom_range(0, 1) == 1) wr(a, d, 4'($urandom_range(0, 15)));
            else rd(a, int'($urandom_range(0, 2)));
        end
        status_in = IDLE;

        // Reset while a read response and a start pulse are pending
        axi.araddr = 5'h08; axi.arvalid = 1; axi.rready = 0;
        axi.awaddr = 5'h04; axi.wdata = 32'h1; axi.wstrb = 4'hF;
        axi.awvalid = 1; axi.wvalid = 1; axi.bready = 0;
        cyc();
        axi.arvalid = 0; axi.awvalid = 0; axi.wvalid = 0;
        check("mid_rvalid", {31'd0, axi.rvalid}, 1);
        check("mid_pulse", {31'd0, enable_out}, 1);
        rst_n = 0;
        #1;
        check("async_rvalid", {31'd0, axi.rvalid}, 0);
        check("async_bvalid", {31'd0, axi.bvalid}, 0);
        check("async_pulse", {31'd0, enable_out}, 0);
        do_reset();
        rd(5'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/custom_axi_ip_regs.md
Name: custom_axi_ip_regs

Overview:
- AXI4-Lite slave register file that sits directly upstream of the custom IP processing core.
- Converts bus writes into the core's ipreg_data / enable_in stimulus.
- Exposes the core's result and state to software as read-only registers.
- One clock domain. No outstanding-transaction queuing: at most one write and one read in flight.

Parameters:
- ADDR_WIDTH, 5: AXI address width. Byte address; the decode uses addr[4:2].
- DATA_WIDTH, 32: AXI data width. Fixed at 32; any other value is a lint/elab error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  write byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- ipreg_data  out  32  operand to core (DATA_IN register)
- enable_out  out  1  one-cycle start pulse to core (drives core enable_in)
- result_in  in  32  core result (core ipreg_data_out)
- status_in  in  2  core state, type status_e

Behaviour:
- Reset values: bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, ipreg_data=0, enable_out=0, sticky flags=0.
- Register map:
  - 0x00 DATA_IN: RW, byte-strobed, drives ipreg_data.
  - 0x04 CTRL: write bit0=1 issues START; reads 0.
  - 0x08 RESULT: RO, returns result_in.
  - 0x0C STATUS: [1:0]=status_in, [2]=DONE_STICKY, [3]=START_ERR; bits 2 and 3 are W1C.
  - 0x10-0x1C: unmapped.
- Write channel:
  - awready = wready = awvalid & wvalid & ~bvalid (both channels accepted together in the same cycle).
  - Register update happens on the accepting edge; bvalid rises the next cycle.
  - bvalid holds until bready. bresp=OKAY (00) for mapped addresses, SLVERR (10) for unmapped.
  - Writes to RO registers are ignored and return OKAY.
- Read channel:
  - arready = ~rvalid.
  - On accept, rdata/rresp are registered and rvalid rises the next cycle.
  - rdata is held stable until rready. An unmapped read returns rdata=0 with SLVERR.
- START:
  - A CTRL write with wdata[0]=1 and wstrb[0]=1 while status_in==IDLE pulses enable_out high for exactly one cycle, the cycle after accept.
  - If status_in!=IDLE, no pulse is issued and START_ERR is set.
- DONE_STICKY is set in any cycle where status_in==DONE.
- Set vs clear: if a set condition and a W1C clear land in the same cycle, the set wins.
- Read and write in the same cycle are independent. A read returns the pre-write value of the target register.
- Reset mid-transaction: all valids drop immediately (asynchronous). A pending enable_out pulse is cancelled.

Decomposition:
- custom_axi_ip_pkg holds:
  - status_e (IDLE=0, BUSY=1, DONE=2, ERROR=3)
  - register offset localparams (DATA_IN_OFFS, CTRL_OFFS, RESULT_OFFS, STATUS_OFFS)
  - AXI resp constants (RESP_OKAY, RESP_SLVERR)
- No sub-module. Write and read channel logic stay in one file.

Test Plan:
- Reset, then AW+W to 0x00 with data 0x0000_00A5 and wstrb=0xF → awready/wready high in the accept cycle; bvalid next cycle with bresp=00; ipreg_data=0x0000_00A5.
- Write 0x00 data 0xFFFF_FFFF with wstrb=0x2 → ipreg_data=0x0000_FFA5.
- status_in=IDLE, write 0x04 data 1 → enable_out high exactly one cycle. Repeat with status_in=BUSY → no pulse; a later read of 0x0C returns bit3=1.
- Drive status_in=DONE for 1 cycle and result_in=0x0000_00A6, then read 0x08 and 0x0C → rdata 0x0000_00A6 and bit2=1. Write 0x0C data 0x4 → a re-read returns bit2=0.
- Read 0x14 → rresp=10, rdata=0. Write 0x18 → bresp=10, no register change.
- Hold bready=0 for 5 cycles → bvalid stays high and awready stays low against a new AW/W. Assert rst_ni low mid-read → rvalid=0 immediately.
